instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Multi-cycle fetch stage directly upstream of control_unit.
- Owns the program counter and reads the synchronous instruction memory.
- Holds the current instruction in an instruction register and drives instruction_opcode / instruction_func to control_unit.
- Takes branch/jump decisions back from control_unit and the ALU to select the next PC.

Parameters:
- ADDRESS_WIDTH, 8, word-address width of PC and instruction memory (2..26).
- RESET_PC, 0, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- processor_enable  input  1  allows fetching to start or continue.
- stall  input  1  holds the current instruction in EXECUTE.
- branch  input  1  from control_unit.
- jump  input  1  from control_unit.
- zero  input  1  ALU zero flag.
- imem_data  input  32  instruction memory read data, valid one cycle after imem_read_enable.
- imem_address  output  ADDRESS_WIDTH  instruction memory word address.
- imem_read_enable  output  1  memory read strobe.
- instruction  output  32  instruction register.
- instruction_opcode  output  6  instruction[31:26].
- instruction_func  output  6  instruction[5:0].
- instruction_valid  output  1  high while in EXECUTE.
- pc  output  ADDRESS_WIDTH  current PC.
- retired_count  output  COUNT_WIDTH  instructions completed.

Behaviour:
- Reset (async, takes effect immediately, no clock edge needed):
  - state=IDLE, pc=RESET_PC, instruction=0, retired_count=0.
  - imem_read_enable=0, instruction_valid=0.
  - opcode/func therefore 0.
- States: IDLE, FETCH, LOAD, EXECUTE.
- IDLE:
  - All strobes low.
  - processor_enable=1 at an edge -> FETCH.
- FETCH (1 cycle):
  - imem_address=pc, imem_read_enable=1.
  - Next state: LOAD.
- LOAD (1 cycle):
  - imem_read_enable=0; imem_data is valid this cycle.
  - instruction<=imem_data at the closing edge.
  - Next state: EXECUTE.
- EXECUTE:
  - instruction_valid=1; branch/jump/zero are sampled here.
  - If stall=1: stay in EXECUTE; pc, instruction and retired_count are unchanged.
  - If stall=0, at the closing edge:
    - pc<=next_pc.
    - retired_count<=retired_count+1 (wraps modulo 2^COUNT_WIDTH).
    - State -> FETCH if processor_enable=1, else IDLE.
  - processor_enable going low mid-instruction does not abort it; the instruction completes first.
- next_pc, priority jump > branch > sequential:
  - jump=1: instruction[ADDRESS_WIDTH-1:0].
  - branch=1 and zero=1: pc+1+sign_extend(instruction[15:0]), truncated to ADDRESS_WIDTH (modulo wrap).
  - Otherwise: pc+1, wrapping from all-ones to 0.
  - branch=1 with zero=0 is sequential.
- imem_address:
  - Equals pc in every state.
  - Reads are qualified only by imem_read_enable.
- instruction_opcode and instruction_func are combinational slices of the instruction register. They are stable from EXECUTE entry until the next LOAD edge.
- Throughput: 3 cycles per instruction with no stall; each stalled cycle adds 1.
- Latency:
  - processor_enable rising in IDLE -> first imem_read_enable 1 cycle later.
  - First instruction_valid 3 cycles after enable is sampled.
- Reset asserted mid-operation:
  - Any in-flight fetch is abandoned.
  - No partial PC update.
  - After reset deasserts, the unit restarts from IDLE.

Test Plan:
- Reset/start: hold reset, set processor_enable=1, mem[0]=0x8C010004, release reset -> imem_read_enable=1 with imem_address=0 at the first edge; instruction_valid=1 two cycles later with instruction_opcode=0x23, instruction_func=0x04.
- Sequential: mem[0..2] hold R-type words, no branch/jump, stall=0 -> pc steps 0,1,2,3 every 3 cycles; retired_count=3 after 9 cycles of run.
- Branch: at pc=5, instruction=0x1000FFFD, branch=1.
  - With zero=1 -> next pc=3.
  - Repeat with zero=0 -> next pc=6.
- Jump priority: instruction=0x08000040, jump=1, branch=1, zero=1 -> next pc=0x40.
- Stall: stall=1 for 4 cycles in EXECUTE -> instruction_valid held high for 5 cycles; pc and instruction unchanged; retired_count increments by exactly 1; processor_enable dropped during the stall -> IDLE after completion.
- Wrap/reset: pc=0xFF sequential -> pc=0x00.
  - Then assert reset mid-LOAD -> pc=RESET_PC, instruction=0, strobes low immediately, before the next edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle instruction fetch stage. It owns the PC, reads a synchronous instruction
// memory and holds the current instruction for control_unit while in EXECUTE.
module instruction_fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       COUNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     processor_enable,
  input  logic                     stall,
  input  logic                     branch,
  input  logic                     jump,
  input  logic                     zero,
  input  logic [31:0]              imem_data,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  output logic                     imem_read_enable,
  output logic [31:0]              instruction,
  output logic [5:0]               instruction_opcode,
  output logic [5:0]               instruction_func,
  output logic                     instruction_valid,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [COUNT_WIDTH-1:0]   retired_count,
  output logic [1:0]               state_debug
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    LOAD    = 2'd2,
    EXECUTE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     retire;
  logic [ADDRESS_WIDTH-1:0] pc_seq;
  logic [ADDRESS_WIDTH-1:0] pc_branch;
  logic [ADDRESS_WIDTH-1:0] next_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory read handshake: imem_read_enable is a one-cycle strobe in FETCH with
  // imem_address = pc; the memory returns imem_data on the following cycle (LOAD),
  // where it is captured. There is no back-pressure from the memory side.
  always_comb begin
    state_next        = state;
    imem_read_enable  = 1'b0;
    instruction_valid = 1'b0;
    retire            = 1'b0;
    case (state)
      IDLE: begin
        if (processor_enable) state_next = FETCH;
      end
      FETCH: begin
        imem_read_enable = 1'b1;
        state_next       = LOAD;
      end
      LOAD: begin
        state_next = EXECUTE;
      end
      EXECUTE: begin
        instruction_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          state_next = processor_enable ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Jump beats a taken branch; a branch with zero low falls through sequentially.
  always_comb begin
    pc_seq    = pc + ADDRESS_WIDTH'(1);
    pc_branch = pc_seq + ADDRESS_WIDTH'({{16{instruction[15]}}, instruction[15:0]});
    if (jump)                next_pc = instruction[ADDRESS_WIDTH-1:0];
    else if (branch && zero) next_pc = pc_branch;
    else                     next_pc = pc_seq;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      instruction   <= '0;
      retired_count <= '0;
    end else begin
      if (state == LOAD) instruction <= imem_data;
      if (retire) begin
        pc            <= next_pc;
        retired_count <= retired_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign imem_address       = pc;
  assign instruction_opcode = instruction[31:26];
  assign instruction_func   = instruction[5:0];
  assign state_debug        = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations, then
// randomized stimulus checked every cycle against an instruction-level model.
module tb_instruction_fetch_unit;

  localparam int AW = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          processor_enable = 1'b0;
  logic          stall = 1'b0;
  logic          branch = 1'b0;
  logic          jump = 1'b0;
  logic          zero = 1'b0;
  logic [31:0]   imem_data;
  logic [AW-1:0] imem_address;
  logic          imem_read_enable;
  logic [31:0]   instruction;
  logic [5:0]    instruction_opcode;
  logic [5:0]    instruction_func;
  logic          instruction_valid;
  logic [AW-1:0] pc;
  logic [CW-1:0] retired_count;
  logic [1:0]    state_debug;

  logic [31:0]   mem [256];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [AW-1:0] exp_q[$];

  // Model: which step of the current instruction we are in (0 idle, 1 reading,
  // 2 data returning, 3 executing) plus architectural state.
  int            m_step = 0;
  logic [AW-1:0] m_pc = '0;
  logic [31:0]   m_instr = '0;
  logic [CW-1:0] m_count = '0;

  instruction_fetch_unit #(
    .ADDRESS_WIDTH(AW),
    .RESET_PC     (8'h00),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .processor_enable  (processor_enable),
    .stall             (stall),
    .branch            (branch),
    .jump              (jump),
    .zero              (zero),
    .imem_data         (imem_data),
    .imem_address      (imem_address),
    .imem_read_enable  (imem_read_enable),
    .instruction       (instruction),
    .instruction_opcode(instruction_opcode),
    .instruction_func  (instruction_func),
    .instruction_valid (instruction_valid),
    .pc                (pc),
    .retired_count     (retired_count),
    .state_debug       (state_debug)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_read_enable) imem_data <= mem[imem_address];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] cur, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
    int t;
    if (j) begin
      t = int'(ins[7:0]);
    end else if (b && z) begin
      t = int'(cur) + 1 + int'($signed(ins[15:0]));
    end else begin
      t = int'(cur) + 1;
    end
    t = t & 255;
    return AW'(t);
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_step  = 0;
      m_pc    = '0;
      m_instr = '0;
      m_count = '0;
      exp_q.delete();
    end else begin
      case (m_step)
        0: if (processor_enable) begin
          m_step = 1;
          exp_q.push_back(m_pc);
        end
        1: m_step = 2;
        2: begin
          m_instr = mem[m_pc];
          m_step  = 3;
        end
        default: if (!stall) begin
          m_pc    = model_next(m_pc, m_instr, jump, branch, zero);
          m_count = m_count + 1'b1;
          if (processor_enable) begin
            m_step = 1;
            exp_q.push_back(m_pc);
          end else begin
            m_step = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + fetch scoreboard ----------------
  always @(negedge clock) begin
    check("pc", 32'(pc), 32'(m_pc));
    check("imem_address", 32'(imem_address), 32'(m_pc));
    check("imem_read_enable", 32'(imem_read_enable), 32'(m_step == 1));
    check("instruction_valid", 32'(instruction_valid), 32'(m_step == 3));
    check("instruction", instruction, m_instr);
    check("opcode", 32'(instruction_opcode), 32'(m_instr[31:26]));
    check("func", 32'(instruction_func), 32'(m_instr[5:0]));
    check("retired_count", 32'(retired_count), 32'(m_count));
    if (imem_read_enable) begin
      if (exp_q.size() == 0) check("fetch_order_unexpected_read", 32'(imem_address), 32'hFFFF_FFFF);
      else check("fetch_order", 32'(imem_address), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run_to_exec(input logic [AW-1:0] target);
    int k;
    k = 0;
    while (!(instruction_valid && pc == target) && k < 60) begin
      tick();
      k++;
    end
    check("reach_execute", 32'(instruction_valid && pc == target), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int valid_cycles;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0020;
    mem[8'h00] = 32'h8C01_0004;
    mem[8'h01] = 32'h0022_1820;
    mem[8'h02] = 32'h0043_2020;
    mem[8'h03] = 32'h0064_2822;
    mem[8'h04] = 32'h0085_3024;
    mem[8'h05] = 32'h1000_FFFD;
    mem[8'h06] = 32'h0800_0040;
    mem[8'h40] = 32'h00A6_3820;
    mem[8'h41] = 32'h0800_00FF;
    mem[8'hFF] = 32'h00C7_4025;

    // Reset/start: enable held through reset, first fetch at the first edge.
    processor_enable = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("start_read_enable", 32'(imem_read_enable), 32'd1);
    check("start_address", 32'(imem_address), 32'h00);
    repeat (2) tick();
    check("start_valid", 32'(instruction_valid), 32'd1);
    check("start_opcode", 32'(instruction_opcode), 32'h23);
    check("start_func", 32'(instruction_func), 32'h04);

    // Sequential run: one retire every 3 cycles.
    tick();
    check("seq_pc1", 32'(pc), 32'h01);
    check("seq_count1", 32'(retired_count), 32'd1);
    repeat (3) tick();
    check("seq_pc2", 32'(pc), 32'h02);
    repeat (3) tick();
    check("seq_pc3", 32'(pc), 32'h03);
    check("seq_count3", 32'(retired_count), 32'd3);

    // Branch at pc 5 with offset -3: taken -> 3, not taken -> 6.
    run_to_exec(8'h05);
    branch = 1'b1; zero = 1'b1;
    tick();
    check("branch_taken_pc", 32'(pc), 32'h03);
    branch = 1'b0; zero = 1'b0;
    run_to_exec(8'h05);
    branch = 1'b1;
    tick();
    check("branch_not_taken_pc", 32'(pc), 32'h06);
    branch = 1'b0;

    // Jump overrides a taken branch.
    run_to_exec(8'h06);
    jump = 1'b1; branch = 1'b1; zero = 1'b1;
    tick();
    check("jump_priority_pc", 32'(pc), 32'h40);
    jump = 1'b0; branch = 1'b0; zero = 1'b0;

    // Stall for 4 cycles; enable dropped mid-stall still lets the instruction finish.
    run_to_exec(8'h40);
    check("stall_instr", instruction, 32'h00A6_3820);
    check("stall_count_before", 32'(retired_count), 32'd10);
    stall = 1'b1;
    valid_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instruction_valid) valid_cycles++;
      check("stall_pc_hold", 32'(pc), 32'h40);
      check("stall_instr_hold", instruction, 32'h00A6_3820);
      check("stall_count_hold", 32'(retired_count), 32'd10);
      if (i == 1) processor_enable = 1'b0;
    end
    stall = 1'b0;
    tick();
    check("stall_valid_cycles", 32'(valid_cycles), 32'd5);
    check("stall_done_valid", 32'(instruction_valid), 32'd0);
    check("stall_done_pc", 32'(pc), 32'h41);
    check("stall_done_count", 32'(retired_count), 32'd11);
    tick();
    check("idle_no_read", 32'(imem_read_enable), 32'd0);
    check("idle_pc_hold", 32'(pc), 32'h41);

    // PC wrap from 0xFF, then reset asserted during LOAD.
    processor_enable = 1'b1;
    run_to_exec(8'h41);
    jump = 1'b1;
    tick();
    check("jump_to_ff", 32'(pc), 32'hFF);
    jump = 1'b0;
    run_to_exec(8'hFF);
    tick();
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_count", 32'(retired_count), 32'd13);
    run_to_exec(8'h00);
    tick();
    tick();
    check("pre_reset_pc", 32'(pc), 32'h01);
    reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(pc), 32'h00);
    check("async_reset_instr", instruction, 32'h0);
    check("async_reset_read_enable", 32'(imem_read_enable), 32'd0);
    check("async_reset_valid", 32'(instruction_valid), 32'd0);
    check("async_reset_count", 32'(retired_count), 32'd0);
    check("async_reset_state", 32'(state_debug), 32'd0);
    tick();

    // Randomized run with a random program and occasional resets.
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      processor_enable = ($urandom_range(0, 9) != 0);
      stall            = ($urandom_range(0, 3) == 0);
      branch           = $urandom_range(0, 1) == 1;
      zero             = $urandom_range(0, 1) == 1;
      jump             = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    processor_enable = 1'b0;
    stall = 1'b0;
    repeat (10) tick();
    @(negedge clock);
    #1;
    check("fetch_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
